// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: fetch-stage bundle between the PC, instruction memory and decode.
//   pc_count    current PC                  pc_adv      request accepted, PC may advance
//   imem_req    fetch request               imem_addr   fetch address
//   imem_gnt    memory accepts request      imem_rvalid read data valid (grant order)
//   imem_rdata  instruction word            flush       redirect, drop queued/in-flight work
//   ir_valid    head instruction valid      ir, ir_pc   head instruction and its PC
//   ir_ready    decode consumes head
// slave is the fetch stage's view; master is the surrounding environment's view.
interface ifetch_queue_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            pc_adv;
    logic [XLEN-1:0] pc_count;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            flush;
    logic            ir_valid;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] ir_pc;
    logic            ir_ready;

    modport slave (
        input  pc_count, imem_gnt, imem_rvalid, imem_rdata, flush, ir_ready,
        output pc_adv, imem_req, imem_addr, ir_valid, ir, ir_pc
    );

    modport master (
        output pc_count, imem_gnt, imem_rvalid, imem_rdata, flush, ir_ready,
        input  pc_adv, imem_req, imem_addr, ir_valid, ir, ir_pc
    );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch stage with an in-order prefetch queue.
// Issues IMEM reads at the current PC, pulses pc_adv on grant, records each granted address
// in a pending-address FIFO, pairs returned words with their address in the queue, and
// presents the queue head to decode via ir_valid/ir_ready. flush drops queued entries and
// turns every outstanding fetch into a discard that is silently retired when it returns.
// Ports:
//   clk    clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    ifetch_queue_if.slave (PC, IMEM and decode handshakes)
module ifetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32
) (
    input logic           clk,
    input logic           rst_n,
    ifetch_queue_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW+1:0] DepthW = (CntW + 2)'(DEPTH);

    // occ: queued words, pend: live outstanding, disc: outstanding but flushed
    logic [CntW-1:0] occ_q, occ_d, pend_q, pend_d, disc_q, disc_d;
    logic [PtrW-1:0] q_head_q, q_head_d, q_tail_q, q_tail_d;
    logic [PtrW-1:0] pa_rd_q, pa_rd_d, pa_wr_q, pa_wr_d;
    logic [XLEN-1:0] q_ir_q [DEPTH];
    logic [XLEN-1:0] q_pc_q [DEPTH];
    logic [XLEN-1:0] pa_q   [DEPTH];

    logic [CntW+1:0] inflight;
    logic            grant, rsp_drop, rsp_take, pop, retire, q_wr;

    assign inflight = (CntW + 2)'(occ_q) + (CntW + 2)'(pend_q) + (CntW + 2)'(disc_q);

    assign bus.imem_req  = rst_n & ~bus.flush & (inflight < DepthW);
    assign bus.imem_addr = bus.pc_count;
    assign bus.pc_adv    = grant;
    assign bus.ir_valid  = (occ_q != '0);
    assign bus.ir        = q_ir_q[q_head_q];
    assign bus.ir_pc     = q_pc_q[q_head_q];

    always_comb begin
        grant    = bus.imem_req & bus.imem_gnt;
        // Flushed requests are always older than live ones, so they retire first.
        rsp_drop = bus.imem_rvalid & (disc_q != '0);
        rsp_take = bus.imem_rvalid & (disc_q == '0) & (pend_q != '0);
        retire   = bus.imem_rvalid & ((disc_q != '0) | (pend_q != '0));
        pop      = (occ_q != '0) & bus.ir_ready & ~bus.flush;
        q_wr     = rsp_take & ~bus.flush;

        occ_d    = occ_q;
        pend_d   = pend_q;
        disc_d   = disc_q;
        q_head_d = q_head_q;
        q_tail_d = q_tail_q;
        pa_rd_d  = pa_rd_q;
        pa_wr_d  = pa_wr_q;

        if (bus.flush) begin
            occ_d    = '0;
            q_head_d = q_tail_q;
            pa_rd_d  = pa_wr_q;
            pend_d   = '0;
            // A response arriving in the flush cycle retires one outstanding fetch.
            disc_d   = disc_q + pend_q - CntW'(retire);
        end else begin
            occ_d  = occ_q + CntW'(rsp_take) - CntW'(pop);
            pend_d = pend_q + CntW'(grant) - CntW'(rsp_take);
            disc_d = disc_q - CntW'(rsp_drop);
            if (pop)      q_head_d = q_head_q + PtrW'(1);
            if (rsp_take) begin
                q_tail_d = q_tail_q + PtrW'(1);
                pa_rd_d  = pa_rd_q + PtrW'(1);
            end
            if (grant)    pa_wr_d  = pa_wr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q    <= '0;
            pend_q   <= '0;
            disc_q   <= '0;
            q_head_q <= '0;
            q_tail_q <= '0;
            pa_rd_q  <= '0;
            pa_wr_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_ir_q[i] <= '0;
                q_pc_q[i] <= '0;
                pa_q[i]   <= '0;
            end
        end else begin
            occ_q    <= occ_d;
            pend_q   <= pend_d;
            disc_q   <= disc_d;
            q_head_q <= q_head_d;
            q_tail_q <= q_tail_d;
            pa_rd_q  <= pa_rd_d;
            pa_wr_q  <= pa_wr_d;
            if (grant) pa_q[pa_wr_q] <= bus.pc_count;
            if (q_wr) begin
                q_ir_q[q_tail_q] <= bus.imem_rdata;
                q_pc_q[q_tail_q] <= pa_q[pa_rd_q];
            end
        end
    end
endmodule
